// File: rtl/log_serializer_pkg.sv
// log_serializer_pkg: shared types and constants for the log word serializer,
// also reused by the host-side deframer model.
// Provides the framer state encoding, the default header byte and the
// bytes-per-frame helper.
package log_serializer_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HEAD = 2'd1,
    DATA = 2'd2
  } state_t;

  localparam logic [7:0] HDR_DEFAULT = 8'hA5;

  // Number of data bytes needed to carry an ldw-bit log word.
  function automatic int nb_of(input int ldw);
    return (ldw + 7) / 8;
  endfunction

endpackage

// File: rtl/log_serializer.sv
// log_serializer: turns each LDW-bit log word into a byte frame
//   (optional header byte, then ceil(LDW/8) data bytes, LSB first, tlast on the final byte).
// Latency: first byte of a frame is valid the cycle after the word is accepted;
//   with sto_tready held high one word per NB+HEN cycles, back-to-back with no bubble.
// Backpressure: sto_tready low holds sto_tdata/sto_tlast stable; sti_tready only rises
//   in IDLE or combinationally from sto_tready on the last data byte.
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   sti_tvalid/tready/tdata  input log word stream (LDW bits)
//   sto_tvalid/tready/tdata  output byte stream, sto_tlast marks end of frame
//   cnt_frm                  completed frame counter (wraps)
module log_serializer
  import log_serializer_pkg::*;
#(
  parameter int         LDW = 50,
  parameter int         HEN = 1,
  parameter logic [7:0] HDR = HDR_DEFAULT,
  parameter int         FCW = 16
) (
  input  logic           clk,
  input  logic           rst,
  output logic           sti_tready,
  input  logic           sti_tvalid,
  input  logic [LDW-1:0] sti_tdata,
  input  logic           sto_tready,
  output logic           sto_tvalid,
  output logic [7:0]     sto_tdata,
  output logic           sto_tlast,
  output logic [FCW-1:0] cnt_frm
);

  localparam int            NB       = nb_of(LDW);
  localparam int            CW       = (NB > 1) ? $clog2(NB) : 1;
  localparam int            SHW      = 8 * NB;
  localparam logic [CW-1:0] CNT_LAST = CW'(NB - 1);

  state_t         state, state_n;
  logic [SHW-1:0] sh, sh_n;
  logic [CW-1:0]  cnt, cnt_n;
  logic [FCW-1:0] frm_n;

  logic last_byte;
  logic sti_ttrnsf;
  logic sto_ttrnsf;

  assign last_byte  = (state == DATA) && (cnt == CNT_LAST);
  // Accept a new word while idle, or in the very cycle the final byte leaves,
  // so consecutive frames abut without an idle cycle.
  assign sti_tready = (state == IDLE) || (last_byte && sto_tready);
  assign sti_ttrnsf = sti_tready && sti_tvalid;
  assign sto_tvalid = (state != IDLE);
  assign sto_ttrnsf = sto_tready && sto_tvalid;
  assign sto_tlast  = last_byte;

  always_comb begin
    sto_tdata = 8'h00;
    case (state)
      HEAD:    sto_tdata = HDR;
      DATA:    sto_tdata = sh[7:0];
      default: sto_tdata = 8'h00;
    endcase
  end

  always_comb begin
    state_n = state;
    sh_n    = sh;
    cnt_n   = cnt;
    frm_n   = cnt_frm;
    case (state)
      IDLE: begin
        if (sti_ttrnsf) begin
          sh_n    = SHW'(sti_tdata);
          cnt_n   = '0;
          state_n = (HEN != 0) ? HEAD : DATA;
        end
      end
      HEAD: begin
        if (sto_ttrnsf) begin
          state_n = DATA;
          cnt_n   = '0;
        end
      end
      DATA: begin
        if (sto_ttrnsf) begin
          if (last_byte) begin
            frm_n = cnt_frm + 1'b1;
            // sti_tready is high here, so sti_tvalid alone means a transfer.
            if (sti_ttrnsf) begin
              sh_n    = SHW'(sti_tdata);
              cnt_n   = '0;
              state_n = (HEN != 0) ? HEAD : DATA;
            end else begin
              state_n = IDLE;
            end
          end else begin
            sh_n  = sh >> 8;
            cnt_n = cnt + CW'(1);
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      sh      <= '0;
      cnt     <= '0;
      cnt_frm <= '0;
    end else begin
      state   <= state_n;
      sh      <= sh_n;
      cnt     <= cnt_n;
      cnt_frm <= frm_n;
    end
  end

endmodule

// File: tb/tb_log_serializer.sv
// tb_log_serializer: directed bench for log_serializer.
// Instance A uses defaults (LDW=50, HEN=1, FCW=16); instance B uses LDW=8, HEN=0, FCW=2.
// Inputs are driven 1 time unit after the rising edge, outputs sampled 2 units after it.
module tb_log_serializer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Instance A: defaults
  logic        a_sti_tready, a_sti_tvalid, a_sto_tready, a_sto_tvalid, a_sto_tlast;
  logic [49:0] a_sti_tdata;
  logic [7:0]  a_sto_tdata;
  logic [15:0] a_cnt_frm;

  // Instance B: LDW=8, no header, 2-bit frame counter
  logic        b_sti_tready, b_sti_tvalid, b_sto_tready, b_sto_tvalid, b_sto_tlast;
  logic [7:0]  b_sti_tdata;
  logic [7:0]  b_sto_tdata;
  logic [1:0]  b_cnt_frm;

  log_serializer u_dut_a (
    .clk(clk), .rst(rst),
    .sti_tready(a_sti_tready), .sti_tvalid(a_sti_tvalid), .sti_tdata(a_sti_tdata),
    .sto_tready(a_sto_tready), .sto_tvalid(a_sto_tvalid), .sto_tdata(a_sto_tdata),
    .sto_tlast(a_sto_tlast), .cnt_frm(a_cnt_frm)
  );

  log_serializer #(.LDW(8), .HEN(0), .HDR(8'hA5), .FCW(2)) u_dut_b (
    .clk(clk), .rst(rst),
    .sti_tready(b_sti_tready), .sti_tvalid(b_sti_tvalid), .sti_tdata(b_sti_tdata),
    .sto_tready(b_sto_tready), .sto_tvalid(b_sto_tvalid), .sto_tdata(b_sto_tdata),
    .sto_tlast(b_sto_tlast), .cnt_frm(b_cnt_frm)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Expected byte streams
  logic [7:0] exp1  [8] = '{8'hA5, 8'h05, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h03};
  logic [7:0] exp2a [8] = '{8'hA5, 8'h66, 8'h55, 8'h44, 8'h33, 8'h22, 8'h11, 8'h02};
  logic [7:0] exp2b [8] = '{8'hA5, 8'h0A, 8'h0B, 8'h0C, 8'h0D, 8'h0E, 8'h0F, 8'h00};
  logic [7:0] exp3  [8] = '{8'hA5, 8'hCD, 8'hAB, 8'h89, 8'h67, 8'h45, 8'h23, 8'h01};
  logic [7:0] expb_dat [5] = '{8'h7E, 8'h11, 8'h12, 8'h13, 8'h14};
  logic [1:0] expb_cnt [5] = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

  // Stall tracking across calls of get_byte
  bit         stall_pend = 1'b0;
  logic [7:0] stall_dat;
  logic       stall_last;

  // Results of the back-to-back run
  logic [7:0] bd [16];
  logic       bl [16];
  int         bw [16];
  int         bx [16];

  // Waits for one byte on instance A. Called and returns at posedge+1.
  // rnd=1 forces a stall on the first attempt, then random ready.
  task automatic get_byte(input bit rnd, output logic [7:0] d, output logic l,
                          output logic rdy_in, output int waits, output int xcyc);
    bit x;
    x = 1'b0; d = '0; l = 1'b0; rdy_in = 1'b0; waits = 0; xcyc = 0;
    for (int i = 0; i < 64; i++) begin
      if (!rnd)        a_sto_tready = 1'b1;
      else if (i == 0) a_sto_tready = 1'b0;
      else             a_sto_tready = 1'($urandom_range(0, 1));
      #1;
      if (stall_pend) begin
        check("stall_vld",  {63'd0, a_sto_tvalid}, 64'd1);
        check("stall_dat",  {56'd0, a_sto_tdata}, {56'd0, stall_dat});
        check("stall_last", {63'd0, a_sto_tlast}, {63'd0, stall_last});
      end
      x          = a_sto_tvalid && a_sto_tready;
      stall_pend = a_sto_tvalid && !a_sto_tready;
      stall_dat  = a_sto_tdata;
      stall_last = a_sto_tlast;
      if (x) begin
        d = a_sto_tdata; l = a_sto_tlast; rdy_in = a_sti_tready;
      end
      waits++;
      @(posedge clk); #1;
      if (x) begin
        xcyc = cyc;
        return;
      end
    end
    check("byte_timeout", {63'd0, x}, 64'd1);
  endtask

  // Presents one word on instance A until accepted. Called and returns at posedge+1.
  task automatic feed(input logic [49:0] w, output int acyc);
    bit ok;
    ok = 1'b0;
    a_sti_tdata  = w;
    a_sti_tvalid = 1'b1;
    for (int i = 0; i < 64 && !ok; i++) begin
      @(negedge clk);
      if (a_sti_tready) ok = 1'b1;
      @(posedge clk); #1;
    end
    a_sti_tvalid = 1'b0;
    acyc = cyc;
    check("feed_accept", {63'd0, ok}, 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] d;
    logic       l, r;
    int         w, xc, ac0, ac1;

    a_sti_tvalid = 1'b0; a_sti_tdata = '0; a_sto_tready = 1'b0;
    b_sti_tvalid = 1'b0; b_sti_tdata = '0; b_sto_tready = 1'b0;

    // Reset state
    #12;
    check("rst_a_vld",  {63'd0, a_sto_tvalid}, 64'd0);
    check("rst_a_last", {63'd0, a_sto_tlast},  64'd0);
    check("rst_a_dat",  {56'd0, a_sto_tdata},  64'd0);
    check("rst_a_rdy",  {63'd0, a_sti_tready}, 64'd1);
    check("rst_a_cnt",  {48'd0, a_cnt_frm},    64'd0);
    check("rst_b_vld",  {63'd0, b_sto_tvalid}, 64'd0);
    check("rst_b_rdy",  {63'd0, b_sti_tready}, 64'd1);
    @(posedge clk); #1;
    rst = 1'b0;

    // 1: single frame, ready held high
    feed(50'h3_0000_0000_0005, ac0);
    stall_pend = 1'b0;
    for (int b = 0; b < 8; b++) begin
      get_byte(1'b0, d, l, r, w, xc);
      check($sformatf("t1_dat%0d", b), {56'd0, d}, {56'd0, exp1[b]});
      check($sformatf("t1_last%0d", b), {63'd0, l}, {63'd0, (b == 7)});
      check($sformatf("t1_rdy%0d", b), {63'd0, r}, {63'd0, (b == 7)});
      if (b == 0) check("t1_latency", 64'(w), 64'd1);
    end
    check("t1_cnt", {48'd0, a_cnt_frm}, 64'd1);
    check("t1_idle", {63'd0, a_sto_tvalid}, 64'd0);

    // 2: back-to-back frames
    fork
      begin
        feed(50'h2_1122_3344_5566, ac0);
        feed(50'h0_0F0E_0D0C_0B0A, ac1);
      end
      begin
        for (int k = 0; k < 16; k++) get_byte(1'b0, bd[k], bl[k], r, bw[k], bx[k]);
      end
    join
    for (int k = 0; k < 16; k++) begin
      check($sformatf("t2_dat%0d", k), {56'd0, bd[k]},
            {56'd0, (k < 8) ? exp2a[k] : exp2b[k-8]});
      check($sformatf("t2_last%0d", k), {63'd0, bl[k]}, {63'd0, (k == 7 || k == 15)});
      if (k > 0) check($sformatf("t2_gap%0d", k), 64'(bw[k]), 64'd1);
    end
    check("t2_accept_cyc", 64'(ac1), 64'(bx[7]));
    check("t2_cnt", {48'd0, a_cnt_frm}, 64'd3);

    // 3: backpressure
    feed(50'h1_2345_6789_ABCD, ac0);
    stall_pend = 1'b0;
    for (int b = 0; b < 8; b++) begin
      get_byte(1'b1, d, l, r, w, xc);
      check($sformatf("t3_dat%0d", b), {56'd0, d}, {56'd0, exp3[b]});
      check($sformatf("t3_last%0d", b), {63'd0, l}, {63'd0, (b == 7)});
    end
    check("t3_cnt", {48'd0, a_cnt_frm}, 64'd4);
    a_sto_tready = 1'b1;

    // 4 and 6: LDW=8, HEN=0, counter wrap with FCW=2
    b_sto_tready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      b_sti_tdata  = expb_dat[i];
      b_sti_tvalid = 1'b1;
      @(negedge clk);
      check($sformatf("b_rdy_idle%0d", i), {63'd0, b_sti_tready}, 64'd1);
      @(posedge clk); #1;
      b_sti_tvalid = 1'b0;
      #1;
      check($sformatf("b_vld%0d", i),  {63'd0, b_sto_tvalid}, 64'd1);
      check($sformatf("b_dat%0d", i),  {56'd0, b_sto_tdata}, {56'd0, expb_dat[i]});
      check($sformatf("b_last%0d", i), {63'd0, b_sto_tlast}, 64'd1);
      check($sformatf("b_rdy_xfer%0d", i), {63'd0, b_sti_tready}, 64'd1);
      @(posedge clk); #1;
      check($sformatf("b_cnt%0d", i), {62'd0, b_cnt_frm}, {62'd0, expb_cnt[i]});
      check($sformatf("b_idle%0d", i), {63'd0, b_sto_tvalid}, 64'd0);
      check($sformatf("b_idle_dat%0d", i), {56'd0, b_sto_tdata}, 64'd0);
    end

    // 5: reset mid-frame
    feed(50'h1_2345_6789_ABCD, ac0);
    stall_pend = 1'b0;
    for (int b = 0; b < 3; b++) begin
      get_byte(1'b0, d, l, r, w, xc);
      check($sformatf("t5_pre%0d", b), {56'd0, d}, {56'd0, exp3[b]});
    end
    rst = 1'b1;
    #1;
    check("t5_rst_vld",  {63'd0, a_sto_tvalid}, 64'd0);
    check("t5_rst_cnt",  {48'd0, a_cnt_frm},    64'd0);
    check("t5_rst_last", {63'd0, a_sto_tlast},  64'd0);
    check("t5_rst_rdy",  {63'd0, a_sti_tready}, 64'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    stall_pend = 1'b0;
    feed(50'h3_0000_0000_0005, ac0);
    for (int b = 0; b < 8; b++) begin
      get_byte(1'b0, d, l, r, w, xc);
      check($sformatf("t5_dat%0d", b), {56'd0, d}, {56'd0, exp1[b]});
      check($sformatf("t5_last%0d", b), {63'd0, l}, {63'd0, (b == 7)});
    end
    check("t5_cnt", {48'd0, a_cnt_frm}, 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
